// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard/status inputs and pipeline control outputs of the
// RV32 pipeline sequencer.
//   slave  : the sequencer (consumes ID/EX/MEM status, drives controls)
//   master : the pipeline/test side (drives status, consumes controls)
interface pipe_ctrl_if;
  // ID / EX / MEM status
  logic [4:0]  id_rs;
  logic [4:0]  id_rs2;
  logic        id_uses_rs;
  logic        id_uses_rs2;
  logic        id_fence;
  logic [4:0]  ex_rd;
  logic        ex_is_load;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_pc;
  logic        mem_req;
  logic        mem_ready;
  // pipeline controls
  logic        pc_we;
  logic        pc_sel;
  logic [31:0] redirect_pc;
  logic        if_id_we;
  logic        id_ex_we;
  logic        ex_mem_we;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic        mem_err;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport slave (
    input  id_rs, id_rs2, id_uses_rs, id_uses_rs2, id_fence,
           ex_rd, ex_is_load, ex_branch_taken, ex_branch_pc,
           mem_req, mem_ready,
    output pc_we, pc_sel, redirect_pc, if_id_we, id_ex_we, ex_mem_we,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_err,
           stall_cnt, flush_cnt
  );

  modport master (
    output id_rs, id_rs2, id_uses_rs, id_uses_rs2, id_fence,
           ex_rd, ex_is_load, ex_branch_taken, ex_branch_pc,
           mem_req, mem_ready,
    input  pc_we, pc_sel, redirect_pc, if_id_we, id_ex_we, ex_mem_we,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_err,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline sequencer. Produces per-cycle PC/pipeline
// register enables, flushes and PC select from hazard and status inputs:
// load-use stalls, taken-branch redirects, memory-wait freezes with a
// timeout trap, and a fence drain sequence.
// Ports:
//   clk  - core clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - pipe_ctrl_if.slave (status in, controls out)
// Optional feature: define PIPE_CTRL_PERF_EN to build the stall/flush
// performance counters; otherwise stall_cnt/flush_cnt are tied to 0.
module pipe_ctrl #(
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0010,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);
  localparam int unsigned WAIT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN} state_e;

  state_e              state_q, state_d, ret_state_q, ret_state_d, eff_state;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic                frozen, timeout_hit, load_use, flush_evt;

  assign frozen      = bus.mem_req && !bus.mem_ready;
  // MEM_TIMEOUT == 0 disables the trap entirely.
  assign timeout_hit = (MEM_TIMEOUT != 0) &&
                       (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));
  assign load_use    = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                       ((bus.id_uses_rs  && (bus.id_rs  == bus.ex_rd)) ||
                        (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));
  // The first unfrozen cycle after a wait behaves as the state we left,
  // so a held branch or an interrupted drain proceeds immediately.
  assign eff_state   = (state_q == MEM_WAIT) ? ret_state_q : state_q;

  always_comb begin
    bus.pc_we        = 1'b1;
    bus.if_id_we     = 1'b1;
    bus.id_ex_we     = 1'b1;
    bus.ex_mem_we    = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.ex_mem_flush = 1'b0;
    bus.pc_sel       = 1'b0;
    bus.redirect_pc  = 32'd0;
    bus.mem_err      = 1'b0;
    flush_evt        = 1'b0;
    state_d          = state_q;
    ret_state_d      = ret_state_q;
    wait_cnt_d       = wait_cnt_q;
    drain_cnt_d      = drain_cnt_q;

    if (rst) begin
      bus.pc_we        = 1'b0;
      bus.if_id_we     = 1'b0;
      bus.id_ex_we     = 1'b0;
      bus.ex_mem_we    = 1'b0;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_flush  = 1'b1;
      bus.ex_mem_flush = 1'b1;
    end else if (frozen) begin
      bus.pc_we     = 1'b0;
      bus.if_id_we  = 1'b0;
      bus.id_ex_we  = 1'b0;
      bus.ex_mem_we = 1'b0;
      if (timeout_hit) begin
        bus.mem_err      = 1'b1;
        bus.pc_sel       = 1'b1;
        bus.redirect_pc  = TRAP_VEC;
        bus.pc_we        = 1'b1;
        bus.if_id_flush  = 1'b1;
        bus.id_ex_flush  = 1'b1;
        bus.ex_mem_flush = 1'b1;
        flush_evt        = 1'b1;
        state_d          = RUN;
        ret_state_d      = RUN;
        wait_cnt_d       = '0;
        drain_cnt_d      = '0;
      end else begin
        ret_state_d = eff_state;
        state_d     = MEM_WAIT;
        wait_cnt_d  = wait_cnt_q + 1'b1;
      end
    end else begin
      wait_cnt_d = '0;
      state_d    = eff_state;
      case (eff_state)
        RUN: begin
          if (bus.ex_branch_taken) begin
            bus.pc_sel      = 1'b1;
            bus.redirect_pc = bus.ex_branch_pc;
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
            flush_evt       = 1'b1;
          end else if (bus.id_fence) begin
            bus.pc_we       = 1'b0;
            bus.if_id_we    = 1'b0;
            bus.id_ex_flush = 1'b1;
            drain_cnt_d     = '0;
            state_d         = DRAIN;
          end else if (load_use) begin
            bus.pc_we       = 1'b0;
            bus.if_id_we    = 1'b0;
            bus.id_ex_flush = 1'b1;
          end
        end
        DRAIN: begin
          // Last drain count releases the fence with default outputs.
          if (drain_cnt_q != DRAIN_LAST) begin
            bus.pc_we       = 1'b0;
            bus.if_id_we    = 1'b0;
            bus.id_ex_flush = 1'b1;
            drain_cnt_d     = drain_cnt_q + 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      ret_state_q <= RUN;
      wait_cnt_q  <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_state_q <= ret_state_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, !bus.pc_we};
    flush_cnt_d = flush_cnt_q + {31'd0, flush_evt};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  logic unused_flush_evt;
  assign unused_flush_evt = flush_evt;
  assign bus.stall_cnt    = 32'd0;
  assign bus.flush_cnt    = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed bench for pipe_ctrl. A cycle-level model tracks
// fence stalls remaining and consecutive wait cycles, and a negedge process
// compares every DUT output against it; directed steps add literal checks.
module tb_pipe_ctrl;
  localparam logic [31:0] TRAP = 32'h0000_0010;
  localparam int MT = 4;
  localparam int DC = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.TRAP_VEC(TRAP), .MEM_TIMEOUT(MT), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int          m_wait  = 0;   // consecutive frozen cycles
  bit          m_drain = 0;   // fence in progress
  int          m_rem   = 0;   // fence stall cycles still owed after entry
  logic [31:0] m_stall = 0;
  logic [31:0] m_flush = 0;

  always @(negedge clk) begin
    logic e_pc_we, e_ifw, e_idw, e_exw, e_iff, e_idf, e_exf, e_sel, e_err, evt;
    logic [31:0] e_rpc;
    logic fr, lu;
    fr = bus.mem_req && !bus.mem_ready;
    lu = bus.ex_is_load && bus.ex_rd != 0 &&
         ((bus.id_uses_rs && bus.id_rs == bus.ex_rd) ||
          (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_rd));
    {e_pc_we, e_ifw, e_idw, e_exw} = 4'b1111;
    {e_iff, e_idf, e_exf, e_sel, e_err, evt} = 6'b0;
    e_rpc = 32'd0;
    if (rst) begin
      {e_pc_we, e_ifw, e_idw, e_exw} = 4'b0000;
      {e_iff, e_idf, e_exf} = 3'b111;
      m_wait = 0; m_drain = 0; m_rem = 0;
    end else if (fr) begin
      {e_pc_we, e_ifw, e_idw, e_exw} = 4'b0000;
      m_wait++;
      if (MT != 0 && m_wait == MT) begin
        e_pc_we = 1; e_sel = 1; e_rpc = TRAP; e_err = 1; evt = 1;
        {e_iff, e_idf, e_exf} = 3'b111;
        m_wait = 0; m_drain = 0; m_rem = 0;
      end
    end else begin
      m_wait = 0;
      if (m_drain) begin
        if (m_rem > 0) begin
          e_pc_we = 0; e_ifw = 0; e_idf = 1; m_rem--;
        end else m_drain = 0;
      end else if (bus.ex_branch_taken) begin
        e_sel = 1; e_rpc = bus.ex_branch_pc; e_iff = 1; e_idf = 1; evt = 1;
      end else if (bus.id_fence) begin
        e_pc_we = 0; e_ifw = 0; e_idf = 1; m_drain = 1; m_rem = DC - 1;
      end else if (lu) begin
        e_pc_we = 0; e_ifw = 0; e_idf = 1;
      end
    end
    chk("pc_we",        32'(bus.pc_we),        32'(e_pc_we));
    chk("if_id_we",     32'(bus.if_id_we),     32'(e_ifw));
    chk("id_ex_we",     32'(bus.id_ex_we),     32'(e_idw));
    chk("ex_mem_we",    32'(bus.ex_mem_we),    32'(e_exw));
    chk("if_id_flush",  32'(bus.if_id_flush),  32'(e_iff));
    chk("id_ex_flush",  32'(bus.id_ex_flush),  32'(e_idf));
    chk("ex_mem_flush", 32'(bus.ex_mem_flush), 32'(e_exf));
    chk("pc_sel",       32'(bus.pc_sel),       32'(e_sel));
    chk("redirect_pc",  bus.redirect_pc,       e_rpc);
    chk("mem_err",      32'(bus.mem_err),      32'(e_err));
`ifdef PIPE_CTRL_PERF_EN
    chk("stall_cnt", bus.stall_cnt, m_stall);
    chk("flush_cnt", bus.flush_cnt, m_flush);
`else
    chk("stall_cnt", bus.stall_cnt, 32'd0);
    chk("flush_cnt", bus.flush_cnt, 32'd0);
`endif
    if (rst) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (!e_pc_we) m_stall++;
      if (evt) m_flush++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear();
    bus.id_rs = 0; bus.id_rs2 = 0; bus.id_uses_rs = 0; bus.id_uses_rs2 = 0;
    bus.id_fence = 0; bus.ex_rd = 0; bus.ex_is_load = 0;
    bus.ex_branch_taken = 0; bus.ex_branch_pc = 0;
    bus.mem_req = 0; bus.mem_ready = 0;
  endtask
  task automatic mid();  @(negedge clk); #1; endtask
  task automatic nxt();  @(posedge clk); #1; endtask

  initial begin
    int n;
    rst = 1; clear();
    mid();
    chk("rst_pc_we", 32'(bus.pc_we), 32'd0);
    chk("rst_flush", 32'({bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush}), 32'h7);
    nxt(); mid();
    nxt(); rst = 0; mid();
    chk("post_rst_we", 32'({bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we}), 32'hf);
    chk("post_rst_flush", 32'({bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush}), 32'h0);

    // load-use on rs1
    nxt(); bus.ex_is_load = 1; bus.ex_rd = 5; bus.id_rs = 5; bus.id_uses_rs = 1; mid();
    chk("lu_pc_we", 32'(bus.pc_we), 32'd0);
    chk("lu_if_id_we", 32'(bus.if_id_we), 32'd0);
    chk("lu_id_ex_flush", 32'(bus.id_ex_flush), 32'd1);
    nxt(); clear(); mid();
    chk("lu_one_cycle", 32'(bus.pc_we), 32'd1);
    // load-use on rs2, then rs2 not used
    nxt(); bus.ex_is_load = 1; bus.ex_rd = 7; bus.id_rs2 = 7; bus.id_uses_rs2 = 1; mid();
    chk("lu_rs2", 32'(bus.pc_we), 32'd0);
    nxt(); bus.id_uses_rs2 = 0; mid();
    chk("lu_rs2_unused", 32'(bus.pc_we), 32'd1);
    // x0 never stalls
    nxt(); clear(); bus.ex_is_load = 1; bus.ex_rd = 0; bus.id_rs = 0; bus.id_uses_rs = 1; mid();
    chk("lu_x0", 32'(bus.pc_we), 32'd1);

    // redirect with simultaneous load-use
    nxt(); clear(); bus.ex_branch_taken = 1; bus.ex_branch_pc = 32'h100;
    bus.ex_is_load = 1; bus.ex_rd = 5; bus.id_rs = 5; bus.id_uses_rs = 1; mid();
    chk("br_sel", 32'(bus.pc_sel), 32'd1);
    chk("br_pc", bus.redirect_pc, 32'h100);
    chk("br_flush", 32'({bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush}), 32'h6);
    chk("br_no_stall", 32'({bus.pc_we, bus.if_id_we}), 32'h3);

    // fence, no freeze; a branch during DRAIN is ignored
    n = 0;
    for (int i = 0; i < 4; i++) begin
      nxt(); clear(); bus.id_fence = 1;
      if (i == 1) begin bus.ex_branch_taken = 1; bus.ex_branch_pc = 32'h300; end
      mid();
      if (!bus.pc_we) n++;
      if (i == 1) chk("drain_ign_br", 32'(bus.pc_sel), 32'd0);
      if (i == 3) chk("fence_release", 32'(bus.pc_we), 32'd1);
    end
    chk("fence_stalls", 32'(n), 32'd3);

    // fence with a 2-cycle freeze mid-drain
    n = 0;
    for (int i = 0; i < 6; i++) begin
      nxt(); clear(); bus.id_fence = 1;
      if (i == 2 || i == 3) begin bus.mem_req = 1; bus.mem_ready = 0; end
      if (i == 4) begin bus.mem_req = 1; bus.mem_ready = 1; end
      mid();
      if (!bus.pc_we) n++;
      if (i == 5) chk("fence_frz_release", 32'(bus.pc_we), 32'd1);
    end
    chk("fence_frz_stalls", 32'(n), 32'd5);

    // freeze with held branch (3 cycles, below the 4-cycle timeout)
    for (int i = 0; i < 3; i++) begin
      nxt(); clear(); bus.ex_branch_taken = 1; bus.ex_branch_pc = 32'h200;
      bus.mem_req = 1; mid();
      chk("frz_we", 32'({bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we}), 32'h0);
    end
    nxt(); bus.mem_ready = 1; mid();
    chk("frz_br_sel", 32'(bus.pc_sel), 32'd1);
    chk("frz_br_pc", bus.redirect_pc, 32'h200);

    // timeout
    for (int i = 0; i < 4; i++) begin
      nxt(); clear(); bus.mem_req = 1; mid();
      chk("to_err", 32'(bus.mem_err), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("to_pc", bus.redirect_pc, 32'h10);
    chk("to_flush", 32'({bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush}), 32'h7);
    // back in RUN: a fence enters its drain right away
    nxt(); clear(); bus.id_fence = 1; mid();
    chk("to_run_fence", 32'(bus.pc_we), 32'd0);

    // reset in DRAIN leaves no residual stall
    nxt(); clear(); mid();
    chk("drain_stall", 32'(bus.pc_we), 32'd0);
    nxt(); rst = 1; mid();
    nxt(); rst = 0; mid();
    chk("rst_abort_drain", 32'(bus.pc_we), 32'd1);
    nxt(); mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
